// File: rtl/flit_injector_if.sv
// Injector-side bus: descriptor/payload handshakes from the local source and the
// req / flit_id / length interface towards the output-port arbiter.
interface flit_injector_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 12
);
  logic              pkt_valid;
  logic [LEN_W-1:0]  pkt_len;
  logic              pkt_ready;
  logic [DATA_W-1:0] pay_data;
  logic              pay_valid;
  logic              pay_ready;
  logic              grant;
  logic              req;
  logic [2:0]        flit_id;
  logic [LEN_W-1:0]  length;
  logic [DATA_W-1:0] flit_data;
  logic              flit_valid;
  logic              preempt;

  // Injector side
  modport master (
    input  pkt_valid, pkt_len, pay_data, pay_valid, grant,
    output pkt_ready, pay_ready, req, flit_id, length, flit_data, flit_valid, preempt
  );

  // Source / arbiter side
  modport slave (
    output pkt_valid, pkt_len, pay_data, pay_valid, grant,
    input  pkt_ready, pay_ready, req, flit_id, length, flit_data, flit_valid, preempt
  );
endinterface

// File: rtl/flit_injector.sv
// Wormhole-router input-port injector: takes a descriptor, requests the output
// arbiter and streams header/body/tail flits while grant is held.
module flit_injector #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 12
) (
  input  logic             clk,
  input  logic             rst,
  flit_injector_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam logic [2:0]       FID_NONE = 3'b000;
  localparam logic [2:0]       FID_HEAD = 3'b001;
  localparam logic [2:0]       FID_BODY = 3'b010;
  localparam logic [2:0]       FID_TAIL = 3'b100;
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_MIN  = LEN_W'(2);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              req_q, req_d;
  logic [2:0]        flit_id_q, flit_id_d;
  logic [LEN_W-1:0]  length_q, length_d;
  logic [DATA_W-1:0] flit_data_q, flit_data_d;
  logic              flit_valid_q, flit_valid_d;
  logic              preempt_q, preempt_d;
  logic              grant_q;
  logic [LEN_W-1:0]  len_clamped;

  // Header and tail are mandatory, so anything shorter than two flits becomes two
  assign len_clamped = (bus.pkt_len < LEN_MIN) ? LEN_MIN : bus.pkt_len;

  assign bus.pkt_ready  = (state_q == IDLE);
  assign bus.pay_ready  = (state_q == SEND) && bus.grant;
  assign bus.req        = req_q;
  assign bus.flit_id    = flit_id_q;
  assign bus.length     = length_q;
  assign bus.flit_data  = flit_data_q;
  assign bus.flit_valid = flit_valid_q;
  assign bus.preempt    = preempt_q;

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      rem_q        <= '0;
      req_q        <= 1'b0;
      flit_id_q    <= FID_NONE;
      length_q     <= '0;
      flit_data_q  <= '0;
      flit_valid_q <= 1'b0;
      preempt_q    <= 1'b0;
      grant_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      rem_q        <= rem_d;
      req_q        <= req_d;
      flit_id_q    <= flit_id_d;
      length_q     <= length_d;
      flit_data_q  <= flit_data_d;
      flit_valid_q <= flit_valid_d;
      preempt_q    <= preempt_d;
      grant_q      <= bus.grant;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    rem_d        = rem_q;
    req_d        = req_q;
    flit_id_d    = flit_id_q;
    length_d     = length_q;
    flit_data_d  = flit_data_q;
    flit_valid_d = flit_valid_q;
    preempt_d    = (state_q == SEND) && grant_q && !bus.grant;

    unique case (state_q)
      IDLE: begin
        flit_valid_d = 1'b0;
        flit_id_d    = FID_NONE;
        if (bus.pkt_valid) begin
          len_d    = len_clamped;
          length_d = len_clamped;
          req_d    = 1'b1;
          state_d  = REQ;
        end
      end

      // Flit outputs are left untouched while waiting for the arbiter
      REQ: begin
        if (bus.grant) begin
          flit_id_d    = FID_HEAD;
          flit_valid_d = 1'b1;
          flit_data_d  = DATA_W'(len_q);
          rem_d        = len_q - LEN_ONE;
          state_d      = SEND;
        end
      end

      // A stall never re-sends the header; the next pending payload goes on re-grant
      SEND: begin
        if (bus.grant && bus.pay_valid) begin
          flit_valid_d = 1'b1;
          flit_data_d  = bus.pay_data;
          if (rem_q == LEN_ONE) begin
            flit_id_d = FID_TAIL;
            req_d     = 1'b0;
            length_d  = '0;
            state_d   = IDLE;
          end else begin
            flit_id_d = FID_BODY;
            rem_d     = rem_q - LEN_ONE;
          end
        end else begin
          flit_valid_d = 1'b0;
          flit_id_d    = FID_NONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
